// File: rtl/intc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intc_pkg                                                                 |
// | Register offsets, FSM state encoding and ISR fields for intc_reg.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package intc_pkg;

    localparam int c_MAX_IRQ = 16;

    // Word offsets, compared against bs_addr_i[7:2]
    localparam logic [5:0] c_OFS_IPR  = 6'h00;  // 0x00
    localparam logic [5:0] c_OFS_IER  = 6'h01;  // 0x04
    localparam logic [5:0] c_OFS_ITR  = 6'h02;  // 0x08
    localparam logic [5:0] c_OFS_IPRA = 6'h04;  // 0x10
    localparam logic [5:0] c_OFS_IPRB = 6'h05;  // 0x14
    localparam logic [5:0] c_OFS_ISR  = 6'h06;  // 0x18

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_REQ  = 2'd1;
    localparam state_t c_ST_HOLD = 2'd2;

    localparam int c_ISR_REQ_BIT = 31;
    localparam int c_ISR_LVL_LSB = 8;
    localparam int c_ISR_VEC_LSB = 0;

    function automatic logic [c_MAX_IRQ-1:0] irq_mask(input int n);
        logic [c_MAX_IRQ-1:0] m;
        for (int i = 0; i < c_MAX_IRQ; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    function automatic logic [4*c_MAX_IRQ-1:0] prio_mask(input int n);
        logic [4*c_MAX_IRQ-1:0] m;
        for (int i = 0; i < c_MAX_IRQ; i++) begin
            m[4*i +: 4] = (i < n) ? 4'hF : 4'h0;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intc_prio_arb                                                            |
// | Combinational highest-priority selector, ties go to the lowest index.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module intc_prio_arb
    import intc_pkg::*;
(
    input  logic [c_MAX_IRQ-1:0]   i_cand,
    input  logic [4*c_MAX_IRQ-1:0] i_prio,
    output logic                   o_found,
    output logic [3:0]             o_idx,
    output logic [3:0]             o_level
);

    logic       w_found;
    logic [3:0] w_idx;
    logic [3:0] w_level;

    // Strict '>' on an ascending scan keeps the lowest index on ties
    always_comb begin
        w_found = 1'b0;
        w_idx   = 4'd0;
        w_level = 4'd0;
        for (int i = 0; i < c_MAX_IRQ; i++) begin
            if (i_cand[i] && (i_prio[4*i +: 4] > w_level)) begin
                w_found = 1'b1;
                w_idx   = 4'(i);
                w_level = i_prio[4*i +: 4];
            end
        end
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;
    assign o_level = w_level;

endmodule
`default_nettype wire

// File: rtl/intc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intc_reg                                                                 |
// | Prioritised interrupt controller with register file and CPU handshake.   |
// | Optional macro INTC_IRQ_SYNC_EN adds a 2-flop irq_i synchronizer.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module intc_reg
    import intc_pkg::*;
#(
    parameter int         NUM_IRQ  = 16,
    parameter logic [7:0] VEC_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bs_sel_i,
    input  logic               bs_wr_i,
    input  logic [31:0]        bs_addr_i,
    input  logic [31:0]        bs_wdata_i,
    output logic [31:0]        rg_rdata_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               int_ack_i,
    output logic               int_req_o,
    output logic [3:0]         int_level_o,
    output logic [7:0]         int_vec_o
);

    localparam logic [c_MAX_IRQ-1:0]   c_IRQ_MASK  = irq_mask(NUM_IRQ);
    localparam logic [4*c_MAX_IRQ-1:0] c_PRIO_MASK = prio_mask(NUM_IRQ);

    logic [c_MAX_IRQ-1:0]   w_irq_raw, w_irq_in;
    logic [c_MAX_IRQ-1:0]   r_irq_q, r_irq_q_prev;
    logic [c_MAX_IRQ-1:0]   r_ier, r_itr, r_sticky;
    logic [4*c_MAX_IRQ-1:0] r_prio;
    logic [c_MAX_IRQ-1:0]   w_rise, w_pend, w_ipr_view, w_cand;
    logic [c_MAX_IRQ-1:0]   w_w1c, w_ack_clr, w_itr_next, w_sticky_next;
    logic [5:0]             w_ofs;
    logic                   w_wr_en, w_rd_en;
    logic                   w_found;
    logic [3:0]             w_win_idx, w_win_lvl;
    state_t                 r_state, w_state_next;
    logic                   r_req;
    logic [3:0]             r_level, r_idx;
    logic [7:0]             r_vec;
    logic                   w_unused;

    assign w_unused = ^{bs_addr_i[31:8], bs_addr_i[1:0]};
    assign w_ofs    = bs_addr_i[7:2];
    assign w_wr_en  = bs_sel_i & bs_wr_i;
    assign w_rd_en  = bs_sel_i & ~bs_wr_i;

    always_comb begin
        w_irq_raw = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_irq_raw[i] = irq_i[i];
        end
    end

`ifdef INTC_IRQ_SYNC_EN
    logic [c_MAX_IRQ-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_irq_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_in = r_sync2;
`else
    assign w_irq_in = w_irq_raw;
`endif

    // Edge sources read back a rise as soon as it is sampled, before it lands in the sticky bit
    assign w_rise     = r_irq_q & ~r_irq_q_prev;
    assign w_pend     = (r_itr & r_sticky) | (~r_itr & r_irq_q);
    assign w_ipr_view = (r_itr & (r_sticky | w_rise)) | (~r_itr & r_irq_q);

    always_comb begin
        w_cand = '0;
        for (int i = 0; i < c_MAX_IRQ; i++) begin
            w_cand[i] = w_pend[i] & r_ier[i] & (r_prio[4*i +: 4] != 4'd0);
        end
    end

    intc_prio_arb u_arb (
        .i_cand  (w_cand),
        .i_prio  (r_prio),
        .o_found (w_found),
        .o_idx   (w_win_idx),
        .o_level (w_win_lvl)
    );

    assign w_w1c      = (w_wr_en && (w_ofs == c_OFS_IPR)) ? bs_wdata_i[c_MAX_IRQ-1:0] : '0;
    assign w_ack_clr  = ((r_state == c_ST_REQ) && int_ack_i) ? (c_MAX_IRQ'(1) << r_idx) : '0;
    assign w_itr_next = (w_wr_en && (w_ofs == c_OFS_ITR)) ?
                        (bs_wdata_i[c_MAX_IRQ-1:0] & c_IRQ_MASK) : r_itr;
    // A new rise wins over a W1C/ack clear; turning a source to level drops its sticky bit
    assign w_sticky_next = ((r_sticky & ~w_w1c & ~w_ack_clr) | w_rise) & w_itr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q      <= '0;
            r_irq_q_prev <= '0;
            r_ier        <= '0;
            r_itr        <= '0;
            r_sticky     <= '0;
            r_prio       <= '0;
        end else begin
            r_irq_q      <= w_irq_in;
            r_irq_q_prev <= r_irq_q;
            r_itr        <= w_itr_next;
            r_sticky     <= w_sticky_next;
            if (w_wr_en && (w_ofs == c_OFS_IER)) begin
                r_ier <= bs_wdata_i[c_MAX_IRQ-1:0] & c_IRQ_MASK;
            end
            if (w_wr_en && (w_ofs == c_OFS_IPRA)) begin
                r_prio[31:0] <= bs_wdata_i & c_PRIO_MASK[31:0];
            end
            if (w_wr_en && (w_ofs == c_OFS_IPRB)) begin
                r_prio[63:32] <= bs_wdata_i & c_PRIO_MASK[63:32];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_found) w_state_next = c_ST_REQ;
            c_ST_REQ: begin
                if (int_ack_i)     w_state_next = c_ST_HOLD;
                else if (!w_found) w_state_next = c_ST_IDLE;
            end
            c_ST_HOLD: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Outputs are refreshed every REQ cycle so a higher-priority arrival preempts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_req   <= 1'b0;
            r_level <= 4'd0;
            r_vec   <= 8'd0;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == c_ST_REQ) begin
                r_req   <= 1'b1;
                r_level <= w_win_lvl;
                r_vec   <= VEC_BASE + {4'd0, w_win_idx};
                r_idx   <= w_win_idx;
            end else begin
                r_req   <= 1'b0;
                r_level <= 4'd0;
                r_vec   <= 8'd0;
            end
        end
    end

    assign int_req_o   = r_req;
    assign int_level_o = r_level;
    assign int_vec_o   = r_vec;

    always_comb begin
        rg_rdata_o = '0;
        if (w_rd_en) begin
            case (w_ofs)
                c_OFS_IPR:  rg_rdata_o = {16'd0, w_ipr_view};
                c_OFS_IER:  rg_rdata_o = {16'd0, r_ier};
                c_OFS_ITR:  rg_rdata_o = {16'd0, r_itr};
                c_OFS_IPRA: rg_rdata_o = r_prio[31:0];
                c_OFS_IPRB: rg_rdata_o = r_prio[63:32];
                c_OFS_ISR: begin
                    rg_rdata_o[c_ISR_REQ_BIT]      = r_req;
                    rg_rdata_o[c_ISR_LVL_LSB +: 4] = r_level;
                    rg_rdata_o[c_ISR_VEC_LSB +: 8] = r_vec;
                end
                default: rg_rdata_o = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intc_reg                                                              |
// | Directed bench for intc_reg with a behavioural reference model.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_intc_reg;

    localparam int         NI = 12;
    localparam logic [7:0] VB = 8'h40;

    logic          clk = 1'b0;
    logic          rst;
    logic          bs_sel_i, bs_wr_i;
    logic [31:0]   bs_addr_i, bs_wdata_i;
    logic [31:0]   rg_rdata_o;
    logic [NI-1:0] irq_i;
    logic          int_ack_i;
    logic          int_req_o;
    logic [3:0]    int_level_o;
    logic [7:0]    int_vec_o;

    int n_tests = 0;
    int n_fail  = 0;

    intc_reg #(.NUM_IRQ(NI), .VEC_BASE(VB)) dut (
        .clk         (clk),
        .rst         (rst),
        .bs_sel_i    (bs_sel_i),
        .bs_wr_i     (bs_wr_i),
        .bs_addr_i   (bs_addr_i),
        .bs_wdata_i  (bs_wdata_i),
        .rg_rdata_o  (rg_rdata_o),
        .irq_i       (irq_i),
        .int_ack_i   (int_ack_i),
        .int_req_o   (int_req_o),
        .int_level_o (int_level_o),
        .int_vec_o   (int_vec_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [15:0] m_ier, m_itr, m_stk, m_q, m_qp, m_s1, m_s2;
    bit [3:0]  m_pr[16];
    int        m_st;      // 0 idle, 1 requesting, 2 hold
    bit        m_req;
    bit [3:0]  m_lvl, m_idx;
    bit [7:0]  m_vec;
    bit        m_valid = 1'b0;

    function automatic bit [31:0] m_read(input logic [31:0] a);
        bit [31:0] r;
        r = 0;
        case (a[7:2])
            6'h00: for (int i = 0; i < 16; i++)
                       r[i] = m_itr[i] ? (m_stk[i] | (m_q[i] & ~m_qp[i])) : m_q[i];
            6'h01: r = {16'd0, m_ier};
            6'h02: r = {16'd0, m_itr};
            6'h04: for (int i = 0; i < 8; i++) r[4*i +: 4] = m_pr[i];
            6'h05: for (int i = 0; i < 8; i++) r[4*i +: 4] = m_pr[i+8];
            6'h06: r = (32'(m_req) << 31) | (32'(m_lvl) << 8) | 32'(m_vec);
            default: r = 0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        bit [15:0] raw, pend, w1c, ack, nitr, mask;
        bit        found;
        int        wi, wp;
        raw  = 0;
        mask = 0;
        for (int i = 0; i < NI; i++) begin
            raw[i]  = irq_i[i];
            mask[i] = 1'b1;
        end
        if (rst) begin
            m_ier = 0; m_itr = 0; m_stk = 0; m_q = 0; m_qp = 0; m_s1 = 0; m_s2 = 0;
            for (int i = 0; i < 16; i++) m_pr[i] = 0;
            m_st = 0; m_req = 0; m_lvl = 0; m_vec = 0; m_idx = 0;
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) pend[i] = m_itr[i] ? m_stk[i] : m_q[i];
            found = 0; wi = 0; wp = 0;
            for (int p = 15; p >= 1 && !found; p--)
                for (int i = 0; i < NI && !found; i++)
                    if (pend[i] && m_ier[i] && m_pr[i] == p) begin
                        found = 1; wi = i; wp = p;
                    end
            w1c  = (bs_sel_i && bs_wr_i && bs_addr_i[7:2] == 6'h00) ? bs_wdata_i[15:0] : 16'd0;
            ack  = 0;
            if (m_st == 1 && int_ack_i) ack[m_idx] = 1'b1;
            nitr = (bs_sel_i && bs_wr_i && bs_addr_i[7:2] == 6'h02) ? (bs_wdata_i[15:0] & mask) : m_itr;
            m_stk = ((m_stk & ~w1c & ~ack) | (m_q & ~m_qp)) & nitr;
            m_itr = nitr;
            if (bs_sel_i && bs_wr_i) begin
                if (bs_addr_i[7:2] == 6'h01) m_ier = bs_wdata_i[15:0] & mask;
                if (bs_addr_i[7:2] == 6'h04)
                    for (int i = 0; i < 8; i++) if (i < NI) m_pr[i] = bs_wdata_i[4*i +: 4];
                if (bs_addr_i[7:2] == 6'h05)
                    for (int i = 8; i < 16; i++) if (i < NI) m_pr[i] = bs_wdata_i[4*(i-8) +: 4];
            end
            case (m_st)
                0:       m_st = found ? 1 : 0;
                1:       m_st = int_ack_i ? 2 : (found ? 1 : 0);
                default: m_st = 0;
            endcase
            if (m_st == 1) begin
                m_req = 1; m_lvl = 4'(wp); m_idx = 4'(wi); m_vec = 8'(VB + 8'(wi));
            end else begin
                m_req = 0; m_lvl = 0; m_vec = 0;
            end
            m_qp = m_q;
`ifdef INTC_IRQ_SYNC_EN
            m_q  = m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
`else
            m_q  = raw;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("req",   32'(int_req_o),   32'(m_req));
            check("level", 32'(int_level_o), 32'(m_lvl));
            check("vec",   32'(int_vec_o),   32'(m_vec));
            check("rdata", rg_rdata_o, (bs_sel_i && !bs_wr_i) ? m_read(bs_addr_i) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bs_sel_i = 1; bs_wr_i = 1; bs_addr_i = a; bs_wdata_i = d;
        tick();
        bs_sel_i = 0; bs_wr_i = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bs_sel_i = 1; bs_wr_i = 0; bs_addr_i = a;
        #1;
        check(name, rg_rdata_o, exp);
        bs_sel_i = 0;
    endtask

    task automatic out_chk(input string name, input logic r, input logic [3:0] l, input logic [7:0] v);
        check({name, "_req"}, 32'(int_req_o),   32'(r));
        check({name, "_lvl"}, 32'(int_level_o), 32'(l));
        check({name, "_vec"}, 32'(int_vec_o),   32'(v));
    endtask

    task automatic do_reset();
        irq_i = 0; int_ack_i = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; bs_sel_i = 0; bs_wr_i = 0; bs_addr_i = 0; bs_wdata_i = 0;
        irq_i = 0; int_ack_i = 0;
        tick(); tick();
        out_chk("reset", 0, 0, 8'h00);
        rst = 0;
        rd(32'h04, 32'h0, "reset_ier");

        // single edge source, acknowledged
        wr(32'h04, 32'h1); wr(32'h08, 32'h1); wr(32'h10, 32'h5);
        irq_i = 12'h001; tick();
        irq_i = 12'h000;
        rd(32'h00, 32'h1, "ipr_edge_seen");
        tick(); tick();
        out_chk("edge_req", 1, 4'd5, 8'h40);
        int_ack_i = 1; tick(); int_ack_i = 0;
        out_chk("hold", 0, 0, 8'h00);
        rd(32'h00, 32'h0, "ipr_after_ack");
        tick();
        out_chk("idle", 0, 0, 8'h00);
        tick();
        out_chk("no_rereq", 0, 0, 8'h00);

        // two level sources, preemption falls back when the higher one drops
        do_reset();
        wr(32'h04, 32'h084); wr(32'h08, 32'h0); wr(32'h10, 32'h9000_0300);
        irq_i = 12'h084; tick(); tick();
        out_chk("lvl_hi", 1, 4'd9, 8'h47);
        rd(32'h18, 32'h8000_0947, "isr_hi");
        irq_i = 12'h004; tick(); tick();
        out_chk("lvl_lo", 1, 4'd3, 8'h42);
        rd(32'h18, 32'h8000_0342, "isr_lo");
        rd(32'h1C, 32'h0, "unmapped");

        // equal priority tie
        do_reset();
        wr(32'h04, 32'h012); wr(32'h10, 32'h0006_0060);
        irq_i = 12'h012; tick(); tick();
        out_chk("tie", 1, 4'd6, 8'h41);

        // W1C colliding with a new edge, plain W1C, ITR clear
        do_reset();
        wr(32'h08, 32'h1);
        irq_i = 12'h001; tick(); irq_i = 0; tick();
        irq_i = 12'h001; tick();
        wr(32'h00, 32'h1);
        irq_i = 0;
        rd(32'h00, 32'h1, "w1c_vs_edge");
        wr(32'h00, 32'h1);
        rd(32'h00, 32'h0, "w1c_clear");
        irq_i = 12'h001; tick(); irq_i = 0; tick();
        rd(32'h00, 32'h1, "sticky_again");
        wr(32'h08, 32'h0);
        rd(32'h00, 32'h0, "itr_clear");
        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, 32'h0000_0FFF, "ier_mask");
        wr(32'h14, 32'hFFFF_FFFF);
        rd(32'h14, 32'h0000_FFFF, "iprb_mask");

        // reset while requesting
        do_reset();
        wr(32'h04, 32'h008); wr(32'h10, 32'h0000_2000);
        irq_i = 12'h008; tick(); tick();
        out_chk("pre_rst", 1, 4'd2, 8'h43);
        rst = 1; int_ack_i = 1; tick();
        out_chk("mid_rst", 0, 0, 8'h00);
        rd(32'h04, 32'h0, "ier_after_rst");
        rst = 0; int_ack_i = 0; irq_i = 0; tick();

        // mixed traffic against the model
        do_reset();
        wr(32'h04, 32'h0FFF); wr(32'h08, 32'h00F0);
        wr(32'h10, 32'h3502_0746); wr(32'h14, 32'h0000_9A1F);
        for (int n = 0; n < 300; n++) begin
            irq_i     = irq_i ^ (12'($urandom) & 12'($urandom) & 12'($urandom));
            int_ack_i = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: begin
                    bs_sel_i = 1; bs_wr_i = 1; bs_addr_i = 32'h0; bs_wdata_i = $urandom;
                end
                1, 2: begin
                    bs_sel_i = 1; bs_wr_i = 0; bs_addr_i = 32'($urandom_range(0, 7)) << 2;
                end
                default: begin
                    bs_sel_i = 0; bs_wr_i = 0;
                end
            endcase
            tick();
        end
        bs_sel_i = 0; bs_wr_i = 0; int_ack_i = 0; irq_i = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intc_reg.md
INTC_REG -- requirements
Module: intc_reg

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, meaning the number of interrupt sources (legal range 1..16).
REQ-002 SHALL have parameter VEC_BASE, default 8'h40, meaning the vector number issued for source 0.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port bs_sel_i, input, 1, meaning a register access is in its data phase this cycle.
REQ-006 SHALL have port bs_wr_i, input, 1, meaning the access is a write (1) or a read (0).
REQ-007 SHALL have port bs_addr_i, input, 32, meaning the register address; only bits [7:2] are decoded.
REQ-008 SHALL have port bs_wdata_i, input, 32, meaning the write data, valid while bs_sel_i=1.
REQ-009 SHALL have port rg_rdata_o, output, 32, meaning the read data, valid in the same cycle as bs_sel_i.
REQ-010 SHALL have port irq_i, input, NUM_IRQ, meaning the raw interrupt request lines.
REQ-011 SHALL have port int_ack_i, input, 1, meaning a one-cycle CPU acknowledge pulse.
REQ-012 SHALL have port int_req_o, output, 1, meaning an interrupt request to the CPU.
REQ-013 SHALL have port int_level_o, output, 4, meaning the priority of the requested interrupt.
REQ-014 SHALL have port int_vec_o, output, 8, meaning the vector of the requested interrupt.

Function
REQ-015 Register map (offset = bs_addr_i[7:2]×4) SHALL be: 0x00 IPR pending, read / W1C; 0x04 IER enable, RW; 0x08 ITR trigger, RW, 1=edge 0=level; 0x10 IPRA priority src0-7, RW, 4 bits each, src0 in [3:0]; 0x14 IPRB priority src8-15, RW; 0x18 ISR status, RO: [31]=int_req_o, [11:8]=int_level_o, [7:0]=int_vec_o.
REQ-016 A write SHALL take effect at the clock edge ending a cycle with bs_sel_i=1 and bs_wr_i=1, and bits at or above NUM_IRQ SHALL be ignored.
REQ-017 rg_rdata_o SHALL be combinational from bs_addr_i when bs_sel_i=1 and bs_wr_i=0, and SHALL be 0 otherwise, for unmapped offsets, and for unimplemented bits.
REQ-018 irq_i SHALL be sampled into irq_q; an edge source SHALL set its sticky pending bit on irq_q & ~irq_q_prev; a level source's IPR bit SHALL equal irq_q and SHALL NOT be writable.
REQ-019 If W1C (or ack clear) and an edge set hit the same bit in the same cycle, the set SHALL win.
REQ-020 Writing ITR bit to 0 SHALL clear that source's sticky pending bit.
REQ-021 A candidate SHALL be a source that is pending, enabled, and has priority != 0; the winner SHALL be the candidate with the highest priority, with ties going to the lowest index.
REQ-022 FSM states SHALL be IDLE, REQ and HOLD.
  - IDLE→REQ when a winner exists.
  - REQ→HOLD on int_ack_i.
  - REQ→IDLE when no winner remains.
  - HOLD→IDLE after exactly one cycle.
REQ-023 In REQ, int_req_o=1, int_level_o=winner priority and int_vec_o=VEC_BASE+winner index SHALL all be registered and updated every cycle, so that a higher-priority arrival preempts.
REQ-024 On int_ack_i in REQ, the registered winner's sticky pending bit SHALL clear (if edge-triggered); int_ack_i outside REQ SHALL be ignored.
REQ-025 In IDLE and HOLD, int_req_o SHALL be 0 and int_level_o and int_vec_o SHALL be 0.
REQ-026 Latency without sync SHALL be: irq_i rising sampled at edge k, visible in IPR after edge k, int_req_o=1 after edge k+1 (level source) or k+2 (edge source).
REQ-027 VEC_BASE+index SHALL wrap modulo 256.

Reset
REQ-028 rst=1 SHALL clear IPR, IER, ITR, IPRA, IPRB, irq_q, irq_q_prev and the sync flops, SHALL force the FSM to IDLE, and SHALL drive int_req_o/int_level_o/int_vec_o to 0.
REQ-029 Reset asserted mid-REQ SHALL drop int_req_o at the next edge, with no ack side effects.

Configuration
REQ-030 With INTC_IRQ_SYNC_EN defined, irq_i SHALL pass through a 2-flop synchronizer before irq_q, adding 2 cycles to every REQ-026 latency.
REQ-031 Without INTC_IRQ_SYNC_EN, irq_i SHALL feed irq_q directly.

Structure
REQ-032 Package intc_pkg SHALL hold the register offset constants, the FSM state enum and the ISR field positions.
REQ-033 Priority selection SHALL be a combinational sub-module intc_prio_arb (inputs: candidate vector and priorities; outputs: found, index, level).

Verification
REQ-034 IER=0x0001, ITR=0x0001, IPRA=0x5, pulse irq_i[0] -> int_req_o=1, int_level_o=5, int_vec_o=0x40; ack -> IPR[0]=0, HOLD one cycle, then IDLE.
REQ-035 Src2 prio 3 and src7 prio 9 pending and enabled, both level -> vec 0x47, level 9; drop irq_i[7] -> next cycle vec 0x42, level 3.
REQ-036 Src1 and src4 both prio 6 -> vec 0x41 (lowest index wins).
REQ-037 Write IPR=0x0001 in the same cycle as a new edge on src0 -> IPR[0] stays 1.
REQ-038 Read offset 0x1C -> rg_rdata_o=0; read 0x18 during REQ with vec 0x42, level 3 -> 0x8000_0342.
REQ-039 Assert rst while int_req_o=1 -> all outputs 0 next cycle and IER reads 0.
